// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared types and constants for the display multiplexing controller.
//   mux_state_t          : scheduler state (BLANK = all digits dark, ON = one lit)
//   DEFAULT_DWELL_CYCLES : per-digit lit time at a 48 MHz oscillator (0.5 ms)
//   DEFAULT_BLANK_CYCLES : inter-digit dark gap at a 48 MHz oscillator (10 us)
//   max_int()            : elaboration helper used to size the shared counter
// -----------------------------------------------------------------------------
package display_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    ON    = 1'b1
  } mux_state_t;

  localparam int DEFAULT_DWELL_CYCLES = 24000;
  localparam int DEFAULT_BLANK_CYCLES = 480;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/display_mux_ctrl_if.sv
// -----------------------------------------------------------------------------
// display_mux_ctrl_if
// Bundle between the keypad/data logic, the multiplex scheduler and the shared
// seven-segment decoder / digit drivers.
//   digits_in  : nibble per digit, digit i = [4i+3:4i]
//   digit_en   : 1 = digit i may light
//   s_out      : nibble presented to the shared decoder
//   an         : active-low digit enables (0 = lit)
//   frame_done : one-cycle pulse at the start of each new frame
// modport master : data source side (drives digits/enables, observes outputs)
// modport slave  : scheduler side
// -----------------------------------------------------------------------------
interface display_mux_ctrl_if #(
  parameter int NUM_DIGITS = 2
);

  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic [3:0]              s_out;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_done;

  modport master (
    output digits_in,
    output digit_en,
    input  s_out,
    input  an,
    input  frame_done
  );

  modport slave (
    input  digits_in,
    input  digit_en,
    output s_out,
    output an,
    output frame_done
  );

endinterface

// File: rtl/mux_tick_counter.sv
// -----------------------------------------------------------------------------
// mux_tick_counter
// Free-running up counter with clear/load and a terminal-count flag.
//   clk, reset : clock, synchronous active-low reset (count -> 0)
//   clear      : next count is 0 (highest priority after reset)
//   load       : next count is load_val
//   term_val   : value at which tc asserts
//   cnt        : current count
//   tc         : cnt == term_val (combinational from the count register)
// -----------------------------------------------------------------------------
module mux_tick_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] term_val,
  output logic [WIDTH-1:0] cnt,
  output logic             tc
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + WIDTH'(1);
    if (clear) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == term_val);

endmodule

// File: rtl/display_mux_ctrl.sv
// -----------------------------------------------------------------------------
// display_mux_ctrl
// Time-multiplexing scheduler for a shared hex-to-seven-segment decoder.
// Each digit slot is BLANK_CYCLES dark followed by DWELL_CYCLES lit (or dark
// if the digit is disabled), so frame length and brightness do not depend on
// digit_en. Inputs are snapshotted once per frame.
//   clk   : system clock
//   reset : synchronous, active-low
//   bus   : display_mux_ctrl_if.slave (digits_in, digit_en -> s_out, an,
//           frame_done)
// -----------------------------------------------------------------------------
module display_mux_ctrl
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 2,
  parameter int DWELL_CYCLES = DEFAULT_DWELL_CYCLES,
  parameter int BLANK_CYCLES = DEFAULT_BLANK_CYCLES
) (
  input logic              clk,
  input logic              reset,
  display_mux_ctrl_if.slave bus
);

  // Counter holds 0..max-1; floor of 2 keeps the width non-zero.
  localparam int CW = $clog2(max_int(max_int(DWELL_CYCLES, BLANK_CYCLES), 2));
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

  generate
    if (NUM_DIGITS < 2 || DWELL_CYCLES < 1 || BLANK_CYCLES < 1) begin : g_bad_params
      $error("display_mux_ctrl: need NUM_DIGITS>=2, DWELL_CYCLES>=1, BLANK_CYCLES>=1");
    end
  endgenerate

  mux_state_t              state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [IW-1:0]           out_idx_q, out_idx_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0]   en_shadow_q, en_shadow_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    wrap_q, wrap_d;
  logic                    frame_done_q, frame_done_d;
  logic                    capture;
  logic [CW-1:0]           term_val;
  logic [CW-1:0]           cnt;
  logic                    tc;

  // Every phase ends on terminal count, so tc doubles as the counter clear.
  mux_tick_counter #(
    .WIDTH(CW)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (tc),
    .load     (1'b0),
    .load_val ('0),
    .term_val (term_val),
    .cnt      (cnt),
    .tc       (tc)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= BLANK;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      BLANK: begin
        if (tc) state_d = ON;
      end
      ON: begin
        if (tc) begin
          state_d = BLANK;
          idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
        end
      end
      default: state_d = BLANK;
    endcase
  end

  // Output / datapath logic. The anode register follows the FSM one cycle
  // later, so out_idx_q trails idx_q by the same amount to keep s_out aligned
  // with whichever digit is actually lit.
  always_comb begin
    term_val     = (state_q == BLANK) ? CW'(BLANK_CYCLES - 1) : CW'(DWELL_CYCLES - 1);
    capture      = (state_q == BLANK) && (idx_q == '0) && (cnt == '0);
    shadow_d     = capture ? bus.digits_in : shadow_q;
    en_shadow_d  = capture ? bus.digit_en  : en_shadow_q;
    out_idx_d    = idx_q;
    wrap_d       = (state_q == ON) && tc && (idx_q == LAST_IDX);
    frame_done_d = wrap_q;
  end

  // One anode per digit: only the current slot, only while ON, only if enabled.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_an
    assign an_d[gi] = ~((state_q == ON) && (idx_q == IW'(gi)) && en_shadow_q[gi]);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_idx_q    <= '0;
      shadow_q     <= '0;
      en_shadow_q  <= '0;
      an_q         <= '1;
      wrap_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      out_idx_q    <= out_idx_d;
      shadow_q     <= shadow_d;
      en_shadow_q  <= en_shadow_d;
      an_q         <= an_d;
      wrap_q       <= wrap_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.s_out      = shadow_q[{out_idx_q, 2'b00} +: 4];
  assign bus.an         = an_q;
  assign bus.frame_done = frame_done_q;

endmodule
